// File: rtl/pulse_amp_if.sv
// Bundles the per-channel data, control and status vectors of pulse_amp_array.
// The master side drives inputs and controls; the slave side is the amplifier.
interface pulse_amp_if #(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned INPUTS   = 4
);
    logic [CHANNELS*INPUTS-1:0] in;
    logic [CHANNELS-1:0]        en;
    logic [CHANNELS-1:0]        ovr_clr;
    logic [CHANNELS-1:0]        gate_n;
    logic [CHANNELS-1:0]        pulse;
    logic [CHANNELS-1:0]        pulse_n;
    logic [CHANNELS-1:0]        busy;
    logic [CHANNELS-1:0]        ovr;

    modport master (
        output in, en, ovr_clr,
        input  gate_n, pulse, pulse_n, busy, ovr
    );

    modport slave (
        input  in, en, ovr_clr,
        output gate_n, pulse, pulse_n, busy, ovr
    );
endinterface

// File: rtl/pulse_amp_array.sv
// Array of independent pulse amplifiers: AND/NAND gate per channel, rising-edge
// trigger, fixed-width registered pulse with optional retrigger, holdoff and overrun flag.
module pulse_amp_array #(
    parameter int unsigned CHANNELS       = 6,
    parameter int unsigned INPUTS         = 4,
    parameter int unsigned PULSE_CYCLES   = 5,
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter bit          RETRIGGER      = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    pulse_amp_if.slave bus
);
    localparam int unsigned MAX_CYCLES =
        (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    // Only used when HOLDOFF_CYCLES > 0, so the wrap at zero is never loaded.
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_e;

    logic [CHANNELS-1:0] g;
    logic [CHANNELS-1:0] trig;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    logic [CHANNELS-1:0] pulse_w, busy_w;
    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            g[c] = &bus.in[c*INPUTS +: INPUTS];
        end
    end

    assign trig = g & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // prev resets high so inputs already asserted at release do not fire.
            prev_q <= '1;
            ovr_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= StIdle;
                cnt_q[c]   <= '0;
            end
        end else begin
            prev_q <= g;
            ovr_q  <= ovr_d;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            ovr_d[c]   = ovr_q[c] & ~bus.ovr_clr[c];
            unique case (state_q[c])
                StIdle: begin
                    if (trig[c] && bus.en[c]) begin
                        state_d[c] = StPulse;
                        cnt_d[c]   = PULSE_LOAD;
                    end
                end
                StPulse: begin
                    if (RETRIGGER && trig[c] && bus.en[c]) begin
                        cnt_d[c] = PULSE_LOAD;
                    end else begin
                        if (!RETRIGGER && trig[c]) begin
                            ovr_d[c] = 1'b1;
                        end
                        if (cnt_q[c] != '0) begin
                            cnt_d[c] = cnt_q[c] - 1'b1;
                        end else if (HOLDOFF_CYCLES > 0) begin
                            state_d[c] = StHoldoff;
                            cnt_d[c]   = HOLD_LOAD;
                        end else begin
                            state_d[c] = StIdle;
                        end
                    end
                end
                StHoldoff: begin
                    if (trig[c]) begin
                        ovr_d[c] = 1'b1;
                    end
                    if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - 1'b1;
                    end else begin
                        state_d[c] = StIdle;
                    end
                end
                default: begin
                    state_d[c] = StIdle;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            pulse_w[c] = (state_q[c] == StPulse);
            busy_w[c]  = (state_q[c] != StIdle);
        end
    end

    assign bus.gate_n  = ~g;
    assign bus.pulse   = pulse_w;
    assign bus.pulse_n = ~pulse_w;
    assign bus.busy    = busy_w;
    assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_pulse_amp_array.sv
// Bench for pulse_amp_array: three instances (defaults, retrigger, minimal sweep)
// driven from a vector table through a one-deep scoreboard, plus reset/enable sequences.
module tb_pulse_amp_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_amp_if #(.CHANNELS(6), .INPUTS(4)) a_if ();
    pulse_amp_if #(.CHANNELS(6), .INPUTS(4)) b_if ();
    pulse_amp_if #(.CHANNELS(1), .INPUTS(1)) c_if ();

    pulse_amp_array #(
        .CHANNELS(6), .INPUTS(4), .PULSE_CYCLES(5), .HOLDOFF_CYCLES(2), .RETRIGGER(1'b0)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

    pulse_amp_array #(
        .CHANNELS(6), .INPUTS(4), .PULSE_CYCLES(4), .HOLDOFF_CYCLES(2), .RETRIGGER(1'b1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    pulse_amp_array #(
        .CHANNELS(1), .INPUTS(1), .PULSE_CYCLES(1), .HOLDOFF_CYCLES(0), .RETRIGGER(1'b0)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    typedef struct {
        int         dut;
        logic [3:0] in0;
        logic       en0;
        logic       clr0;
        logic       p0;
        logic       b0;
        logic       o0;
        string      name;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic [5:0] pulse;
        logic [5:0] busy;
        logic [5:0] ovr;
        logic [5:0] gate_n;
        logic [5:0] pulse_n;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, req);
        end
    endtask

    function automatic void add(input int d, input logic [3:0] in0, input logic en0,
                                input logic clr0, input logic p0, input logic b0,
                                input logic o0, input string name);
        vec_t v;
        v.dut = d; v.in0 = in0; v.en0 = en0; v.clr0 = clr0;
        v.p0 = p0; v.b0 = b0; v.o0 = o0; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic get_outs(input int d, output logic [5:0] p, output logic [5:0] b,
                            output logic [5:0] o, output logic [5:0] g,
                            output logic [5:0] pn);
        if (d == 0) begin
            p = a_if.pulse; b = a_if.busy; o = a_if.ovr; g = a_if.gate_n; pn = a_if.pulse_n;
        end else if (d == 1) begin
            p = b_if.pulse; b = b_if.busy; o = b_if.ovr; g = b_if.gate_n; pn = b_if.pulse_n;
        end else begin
            p = {5'b0, c_if.pulse};   b = {5'b0, c_if.busy};  o = {5'b0, c_if.ovr};
            g = {5'b0, c_if.gate_n};  pn = {5'b0, c_if.pulse_n};
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t h;
        logic [5:0] p, b, o, g, pn;
        if (v.dut == 0) begin
            a_if.in[3:0] = v.in0; a_if.en[0] = v.en0; a_if.ovr_clr[0] = v.clr0;
        end else if (v.dut == 1) begin
            b_if.in[3:0] = v.in0; b_if.en[0] = v.en0; b_if.ovr_clr[0] = v.clr0;
        end else begin
            c_if.in[0] = v.in0[0]; c_if.en[0] = v.en0; c_if.ovr_clr[0] = v.clr0;
        end
        e.name  = v.name;
        e.dut   = v.dut;
        e.pulse = {5'b0, v.p0};
        e.busy  = {5'b0, v.b0};
        e.ovr   = {5'b0, v.o0};
        if (v.dut == 2) begin
            e.gate_n  = {5'b0, ~v.in0[0]};
            e.pulse_n = {5'b0, ~v.p0};
        end else begin
            e.gate_n  = {5'b11111, ~&v.in0};
            e.pulse_n = {5'b11111, ~v.p0};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        h = sb.pop_front();
        get_outs(h.dut, p, b, o, g, pn);
        check({h.name, ".pulse"}, p, h.pulse);
        check({h.name, ".busy"}, b, h.busy);
        check({h.name, ".ovr"}, o, h.ovr);
        check({h.name, ".gate_n"}, g, h.gate_n);
        check({h.name, ".pulse_n"}, pn, h.pulse_n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Defaults instance: basic pulse, then drop/overrun with set-wins clear.
        add(0, 4'b0111, 1, 0, 0, 0, 0, "a_pre");
        for (int i = 0; i < 5; i++) add(0, 4'b1111, 1, 0, 1, 1, 0, "a_pulse");
        for (int i = 0; i < 2; i++) add(0, 4'b1111, 1, 0, 0, 1, 0, "a_hold");
        for (int i = 0; i < 2; i++) add(0, 4'b1111, 1, 0, 0, 0, 0, "a_held_high");
        add(0, 4'b0111, 1, 0, 0, 0, 0, "a_pre2");
        add(0, 4'b1111, 1, 0, 1, 1, 0, "a_trig2");
        add(0, 4'b0111, 1, 0, 1, 1, 0, "a_low");
        add(0, 4'b1111, 1, 0, 1, 1, 1, "a_drop");
        add(0, 4'b1111, 1, 0, 1, 1, 1, "a_drop_hold");
        add(0, 4'b1111, 1, 0, 1, 1, 1, "a_pulse_last");
        add(0, 4'b0111, 1, 0, 0, 1, 1, "a_hold_low");
        add(0, 4'b1111, 1, 1, 0, 1, 1, "a_set_wins");
        add(0, 4'b1111, 1, 1, 0, 0, 0, "a_clr");
        add(0, 4'b0111, 1, 0, 0, 0, 0, "a_pre3");
        add(0, 4'b1111, 1, 0, 1, 1, 0, "a_trig3");
        // Retrigger instance: reload stretches the pulse to 6 cycles, no overrun.
        add(1, 4'b0000, 1, 0, 0, 0, 0, "b_pre");
        add(1, 4'b1111, 1, 0, 1, 1, 0, "b_trig");
        add(1, 4'b0000, 1, 0, 1, 1, 0, "b_low");
        add(1, 4'b1111, 1, 0, 1, 1, 0, "b_retrig");
        for (int i = 0; i < 3; i++) add(1, 4'b1111, 1, 0, 1, 1, 0, "b_stretch");
        for (int i = 0; i < 2; i++) add(1, 4'b1111, 1, 0, 0, 1, 0, "b_hold");
        add(1, 4'b1111, 1, 0, 0, 0, 0, "b_idle");
        // Minimal instance: one-cycle pulses, edges two clocks apart both accepted.
        add(2, 4'b0000, 1, 0, 0, 0, 0, "c_pre");
        add(2, 4'b0001, 1, 0, 1, 1, 0, "c_trig1");
        add(2, 4'b0000, 1, 0, 0, 0, 0, "c_end1");
        add(2, 4'b0001, 1, 0, 1, 1, 0, "c_trig2");
        add(2, 4'b0000, 1, 0, 0, 0, 0, "c_end2");
        add(2, 4'b0001, 1, 0, 1, 1, 0, "c_trig3");
        add(2, 4'b0001, 1, 0, 0, 0, 0, "c_held");

        a_if.in = '1; a_if.en = '1; a_if.ovr_clr = '0;
        b_if.in = '1; b_if.en = '1; b_if.ovr_clr = '0;
        c_if.in = '1; c_if.en = '1; c_if.ovr_clr = '0;

        // Reset held with all inputs high.
        repeat (3) begin
            tick();
            check("rst.pulse", a_if.pulse, 6'h00);
            check("rst.busy", a_if.busy, 6'h00);
            check("rst.ovr", a_if.ovr, 6'h00);
            check("rst.pulse_n", a_if.pulse_n, 6'h3f);
            check("rst.gate_n", a_if.gate_n, 6'h00);
        end
        check("rst.c_gate_n", {5'b0, c_if.gate_n}, 6'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("rel.pulse", a_if.pulse, 6'h00);
            check("rel.busy", a_if.busy, 6'h00);
            check("rel.gate_n", a_if.gate_n, 6'h00);
            check("rel.b_pulse", b_if.pulse, 6'h00);
            check("rel.c_pulse", {5'b0, c_if.pulse}, 6'h00);
        end
        a_if.in = '0; b_if.in = '0; c_if.in = '0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Disabled trigger on channel 2 is silently discarded.
        a_if.in[11:8] = 4'h0; a_if.en[2] = 1'b0;
        tick();
        a_if.in[11:8] = 4'hf;
        tick();
        check("en_off.pulse2", {5'b0, a_if.pulse[2]}, 6'h00);
        check("en_off.busy2", {5'b0, a_if.busy[2]}, 6'h00);
        tick();
        check("en_off.ovr2", {5'b0, a_if.ovr[2]}, 6'h00);
        check("en_off.pulse2b", {5'b0, a_if.pulse[2]}, 6'h00);

        // Enabled trigger, then asynchronous reset two cycles into the pulse.
        a_if.in[11:8] = 4'h0; a_if.en[2] = 1'b1;
        tick();
        a_if.in[11:8] = 4'hf;
        tick();
        check("en_on.pulse2", {5'b0, a_if.pulse[2]}, 6'h01);
        tick();
        check("en_on.pulse2b", {5'b0, a_if.pulse[2]}, 6'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.pulse2", {5'b0, a_if.pulse[2]}, 6'h00);
        check("async_rst.busy2", {5'b0, a_if.busy[2]}, 6'h00);
        check("async_rst.pulse_n2", {5'b0, a_if.pulse_n[2]}, 6'h01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            check("post_rst.pulse2", {5'b0, a_if.pulse[2]}, 6'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
